// File: rtl/st_bus_pkg.sv
// ----------------------------------------------------------------------------
// st_bus_pkg -- shared definitions for the pipeline stage buses.
//   * widths of the EXE->MEM (106 bit) and MEM->WB (70 bit) buses
//   * bit positions of the fields inside the EXE->MEM bus
//     {ld, st, ls_word, lb_sign, store_data[31:0], exe_result[31:0],
//      wen, wdest[4:0], pc[31:0]}, MSB first
//   * state encoding of the MEM stage controller
// ----------------------------------------------------------------------------
package st_bus_pkg;

   localparam int EXE_MEM_W = 106;
   localparam int MEM_WB_W  = 70;

   // EXE->MEM field positions (single bits, or LSB of multi-bit fields)
   localparam int EM_LD         = 105;
   localparam int EM_ST         = 104;
   localparam int EM_LS_WORD    = 103;
   localparam int EM_LB_SIGN    = 102;
   localparam int EM_SDATA_LSB  = 70;
   localparam int EM_RESULT_LSB = 38;
   localparam int EM_WEN        = 37;
   localparam int EM_WDEST_LSB  = 32;
   localparam int EM_PC_LSB     = 0;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LOAD_WAIT = 2'd1,
      DONE      = 2'd2
   } mem_state_e;

endpackage

// File: rtl/st4_mem_ldext.sv
// ----------------------------------------------------------------------------
// st4_mem_ldext -- load data formatter (combinational).
//   rdata   : raw word returned by the data memory
//   addr    : byte offset of the access inside the word
//   ls_word : 1 = word load (pass whole word), 0 = byte load
//   lb_sign : byte loads only, 1 = sign-extend, 0 = zero-extend
//   result  : value written back to the register file
// ----------------------------------------------------------------------------
module st4_mem_ldext (
   input  logic [31:0] rdata,
   input  logic [1:0]  addr,
   input  logic        ls_word,
   input  logic        lb_sign,
   output logic [31:0] result
);

   logic [7:0] byte_v;

   // NOTE: every signal assigned in always_comb gets a value on every path
   // (defaults first), otherwise a latch is inferred.
   always_comb begin
      byte_v = rdata[{addr, 3'b000} +: 8];
      result = rdata;
      if (!ls_word) begin
         result = {{24{lb_sign & byte_v[7]}}, byte_v};
      end
   end

endmodule

// File: rtl/st4_mem.sv
// ----------------------------------------------------------------------------
// st4_mem -- MEM stage of a multi-cycle CPU.
// Accepts one instruction from EXE, performs at most one data memory access
// (synchronous RAM, read data one cycle after the address) and presents the
// writeback bus with MEM_over until EXE withdraws MEM_valid.
//
// Ports
//   clk, reset      : clock, synchronous active-high reset
//   MEM_valid       : MEM holds a valid instruction (level)
//   EXE_MEM_bus_r   : instruction fields from EXE (see st_bus_pkg)
//   dm_addr/dm_wen/dm_wdata/dm_rdata : data memory interface
//   MEM_over        : access complete, MEM_WB_bus valid
//   MEM_WB_bus      : {wen, wdest[4:0], mem_result[31:0], pc[31:0]}
//   mem_misalign    : misaligned word access flag
//   MEM_pc          : pc of the instruction in MEM
//
// Configuration
//   MEM_ALIGN_CHECK_EN : when defined, misaligned word accesses are flagged,
//   their store is suppressed and their writeback disabled. When undefined
//   the low address bits of word accesses are simply forced to zero.
// ----------------------------------------------------------------------------
module st4_mem
   import st_bus_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 MEM_valid,
   input  logic [EXE_MEM_W-1:0] EXE_MEM_bus_r,
   output logic [31:0]          dm_addr,
   output logic [3:0]           dm_wen,
   output logic [31:0]          dm_wdata,
   input  logic [31:0]          dm_rdata,
   output logic                 MEM_over,
   output logic [MEM_WB_W-1:0]  MEM_WB_bus,
   output logic                 mem_misalign,
   output logic [31:0]          MEM_pc
);

   mem_state_e  state;

   logic        ld, st, ls_word, lb_sign, wen;
   logic [31:0] store_data, exe_result, pc;
   logic [4:0]  wdest;
   logic        word_acc;
   logic        misaligned;
   logic [31:0] load_result;

   assign ld         = EXE_MEM_bus_r[EM_LD];
   assign st         = EXE_MEM_bus_r[EM_ST];
   assign ls_word    = EXE_MEM_bus_r[EM_LS_WORD];
   assign lb_sign    = EXE_MEM_bus_r[EM_LB_SIGN];
   assign store_data = EXE_MEM_bus_r[EM_SDATA_LSB +: 32];
   assign exe_result = EXE_MEM_bus_r[EM_RESULT_LSB +: 32];
   assign wen        = EXE_MEM_bus_r[EM_WEN];
   assign wdest      = EXE_MEM_bus_r[EM_WDEST_LSB +: 5];
   assign pc         = EXE_MEM_bus_r[EM_PC_LSB +: 32];

   assign MEM_pc   = pc;
   assign word_acc = (ld | st) & ls_word;

`ifdef MEM_ALIGN_CHECK_EN
   assign misaligned = word_acc && (exe_result[1:0] != 2'b00);
   assign dm_addr    = exe_result;

   // High while the flagged instruction sits in DONE (the bus is held
   // stable by EXE, so the flag is recomputed each cycle it stays there).
   always_ff @(posedge clk) begin
      if (reset) begin
         mem_misalign <= 1'b0;
      end else begin
         mem_misalign <= MEM_valid && (state != IDLE || !ld) && misaligned;
      end
   end
`else
   assign misaligned   = 1'b0;
   assign dm_addr      = word_acc ? {exe_result[31:2], 2'b00} : exe_result;
   assign mem_misalign = 1'b0;
`endif

   // Byte stores replicate the byte on all lanes; the strobe picks the lane.
   assign dm_wdata = ls_word ? store_data : {4{store_data[7:0]}};

   // The strobe is combinational so the RAM writes on the same edge that
   // accepts the instruction; it can therefore fire exactly once.
   always_comb begin
      dm_wen = 4'b0000;
      if (!reset && state == IDLE && MEM_valid && st && !misaligned) begin
         dm_wen = ls_word ? 4'b1111 : (4'b0001 << dm_addr[1:0]);
      end
   end

   st4_mem_ldext u_ldext (
      .rdata   (dm_rdata),
      .addr    (dm_addr[1:0]),
      .ls_word (ls_word),
      .lb_sign (lb_sign),
      .result  (load_result)
   );

   // MEM_WB_bus is zero outside DONE, so an aborted or reset access leaves
   // every output at its reset value.
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         MEM_over   <= 1'b0;
         MEM_WB_bus <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (MEM_valid) begin
                  if (ld) begin
                     state <= LOAD_WAIT;
                  end else begin
                     state      <= DONE;
                     MEM_over   <= 1'b1;
                     MEM_WB_bus <= {wen & ~misaligned, wdest, exe_result, pc};
                  end
               end
            end
            LOAD_WAIT: begin
               if (!MEM_valid) begin
                  state <= IDLE;
               end else begin
                  state      <= DONE;
                  MEM_over   <= 1'b1;
                  MEM_WB_bus <= {wen & ~misaligned, wdest, load_result, pc};
               end
            end
            DONE: begin
               if (!MEM_valid) begin
                  state      <= IDLE;
                  MEM_over   <= 1'b0;
                  MEM_WB_bus <= '0;
               end
            end
            default: begin
               state      <= IDLE;
               MEM_over   <= 1'b0;
               MEM_WB_bus <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_st4_mem.sv
// ----------------------------------------------------------------------------
// tb_st4_mem -- self-checking bench for st4_mem.
// A transaction-level model (instruction age in cycles, expected result from
// a RAM array) is compared against the DUT on every falling edge, alongside
// hand-computed expectations for the directed cases.
// ----------------------------------------------------------------------------
module tb_st4_mem;

   logic         clk = 1'b0;
   logic         reset;
   logic         MEM_valid;
   logic [105:0] EXE_MEM_bus_r;
   logic [31:0]  dm_addr;
   logic [3:0]   dm_wen;
   logic [31:0]  dm_wdata;
   logic [31:0]  dm_rdata;
   logic         MEM_over;
   logic [69:0]  MEM_WB_bus;
   logic         mem_misalign;
   logic [31:0]  MEM_pc;

   // instruction fields driven by the stimulus
   logic        f_ld, f_st, f_lw, f_ls, f_wen;
   logic [31:0] f_sd, f_exe, f_pc;
   logic [4:0]  f_wd;

   assign EXE_MEM_bus_r = {f_ld, f_st, f_lw, f_ls, f_sd, f_exe, f_wen, f_wd, f_pc};

   int n_checks = 0;
   int n_err    = 0;
   logic chk_on = 1'b0;

   st4_mem dut (
      .clk           (clk),
      .reset         (reset),
      .MEM_valid     (MEM_valid),
      .EXE_MEM_bus_r (EXE_MEM_bus_r),
      .dm_addr       (dm_addr),
      .dm_wen        (dm_wen),
      .dm_wdata      (dm_wdata),
      .dm_rdata      (dm_rdata),
      .MEM_over      (MEM_over),
      .MEM_WB_bus    (MEM_WB_bus),
      .mem_misalign  (mem_misalign),
      .MEM_pc        (MEM_pc)
   );

   always #5 clk = ~clk;

   // ---------------- synchronous RAM (1 KiB) ----------------
   logic [31:0] ram [0:255] = '{default: 32'h0};
   logic        pl_en = 1'b0;
   logic [31:0] pl_addr, pl_data;

   always @(posedge clk) begin
      if (pl_en) ram[pl_addr[9:2]] <= pl_data;
      for (int b = 0; b < 4; b++) begin
         if (dm_wen[b]) ram[dm_addr[9:2]][8*b +: 8] <= dm_wdata[8*b +: 8];
      end
      dm_rdata <= ram[dm_addr[9:2]];
   end

   // ---------------- reference model ----------------
   function automatic logic model_mis();
`ifdef MEM_ALIGN_CHECK_EN
      return (f_ld || f_st) && f_lw && (f_exe[1:0] != 2'b00);
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [31:0] model_addr();
`ifdef MEM_ALIGN_CHECK_EN
      return f_exe;
`else
      if ((f_ld || f_st) && f_lw) return f_exe & 32'hFFFF_FFFC;
      return f_exe;
`endif
   endfunction

   function automatic logic [31:0] model_load(input logic [31:0] word, input logic [1:0] a,
                                              input logic lw, input logic ls);
      logic [31:0] bv;
      if (lw) return word;
      bv = (word >> (8 * a)) & 32'hFF;
      if (ls && bv[7]) return 32'hFFFF_FF00 | bv;
      return bv;
   endfunction

   // age = cycles the current instruction has been in MEM; it finishes after
   // 1 cycle (non-load) or 2 cycles (load) and then holds its result.
   int          age = 0;
   logic        m_over = 1'b0;
   logic        m_mis  = 1'b0;
   logic [69:0] m_bus  = '0;

   always @(posedge clk) begin
      int lat;
      lat = f_ld ? 2 : 1;
      if (reset || !MEM_valid) begin
         age    <= 0;
         m_over <= 1'b0;
         m_mis  <= 1'b0;
         m_bus  <= '0;
      end else begin
         age <= (age < 3) ? age + 1 : age;
         if (age + 1 >= lat) begin
            m_over <= 1'b1;
            m_mis  <= model_mis();
            if (!m_over) begin
               m_bus <= {f_wen & ~model_mis(), f_wd,
                         f_ld ? model_load(ram[f_exe[9:2]], f_exe[1:0], f_lw, f_ls) : f_exe,
                         f_pc};
            end
         end
      end
   end

   function automatic logic [3:0] model_wen();
      logic [31:0] a;
      a = model_addr();
      if (reset || !MEM_valid || age != 0 || !f_st || model_mis()) return 4'b0000;
      if (f_lw) return 4'b1111;
      return 4'b0001 << a[1:0];
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // cycle-by-cycle compare against the model
   always @(negedge clk) begin
      logic [3:0] ew;
      if (chk_on) begin
         ew = model_wen();
         check("MEM_over", MEM_over, m_over);
         check("MEM_WB_bus", MEM_WB_bus, m_bus);
         check("mem_misalign", mem_misalign, m_mis);
         check("dm_wen", dm_wen, ew);
         check("MEM_pc", MEM_pc, f_pc);
         if (MEM_valid) check("dm_addr", dm_addr, model_addr());
         if (ew != 4'b0000) check("dm_wdata", dm_wdata, f_lw ? f_sd : {4{f_sd[7:0]}});
      end
   end

   // event counters used by the directed cases
   int wen_pulses  = 0;
   int over_pulses = 0;
   always @(posedge clk) begin
      if (dm_wen != 4'b0000) wen_pulses++;
      if (MEM_over) over_pulses++;
   end

   // ---------------- stimulus helpers ----------------
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic ld, st, lw, ls, input logic [31:0] sd, exe,
                        input logic wen, input logic [4:0] wd, input logic [31:0] pc);
      f_ld = ld; f_st = st; f_lw = lw; f_ls = ls;
      f_sd = sd; f_exe = exe; f_wen = wen; f_wd = wd; f_pc = pc;
      MEM_valid = 1'b1;
   endtask

   task automatic drop();
      MEM_valid = 1'b0;
      step(1);
   endtask

   task automatic preload(input logic [31:0] a, input logic [31:0] d);
      pl_addr = a; pl_data = d; pl_en = 1'b1;
      step(1);
      pl_en = 1'b0;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int base;
      reset = 1'b1;
      MEM_valid = 1'b0;
      f_ld = 0; f_st = 0; f_lw = 0; f_ls = 0; f_wen = 0;
      f_sd = '0; f_exe = '0; f_wd = '0; f_pc = '0;
      step(2);
      chk_on = 1'b1;
      check("reset MEM_over", MEM_over, 1'b0);
      check("reset MEM_WB_bus", MEM_WB_bus, 70'h0);
      check("reset mem_misalign", mem_misalign, 1'b0);
      check("reset dm_wen", dm_wen, 4'b0000);
      reset = 1'b0;
      step(1);

      // ALU pass-through: done one cycle after accept, held while valid
      issue(0, 0, 0, 0, 32'h0, 32'h1234_5678, 1, 5'd5, 32'h0000_0400);
      step(1);
      check("alu MEM_over", MEM_over, 1'b1);
      check("alu MEM_WB_bus", MEM_WB_bus, {1'b1, 5'd5, 32'h1234_5678, 32'h0000_0400});
      step(2);
      check("alu hold", MEM_WB_bus, {1'b1, 5'd5, 32'h1234_5678, 32'h0000_0400});
      drop();
      check("alu release", MEM_over, 1'b0);

      // word load: done two cycles after accept
      preload(32'h100, 32'hDEAD_BEEF);
      issue(1, 0, 1, 0, 32'h0, 32'h0000_0100, 1, 5'd7, 32'h0000_0404);
      step(1);
      check("lw not yet over", MEM_over, 1'b0);
      step(1);
      check("lw MEM_over", MEM_over, 1'b1);
      check("lw result", MEM_WB_bus[63:32], 32'hDEAD_BEEF);
      drop();

      // byte loads from lane 3, signed and unsigned
      preload(32'h100, 32'h80FF_0000);
      issue(1, 0, 0, 1, 32'h0, 32'h0000_0103, 1, 5'd8, 32'h0000_0408);
      step(2);
      check("lb signed", MEM_WB_bus[63:32], 32'hFFFF_FF80);
      drop();
      issue(1, 0, 0, 0, 32'h0, 32'h0000_0103, 1, 5'd9, 32'h0000_040C);
      step(2);
      check("lbu unsigned", MEM_WB_bus[63:32], 32'h0000_0080);
      drop();

      // byte store held for five cycles: one strobe only
      base = wen_pulses;
      issue(0, 1, 0, 0, 32'h0000_00AB, 32'h0000_0202, 0, 5'd0, 32'h0000_0410);
      #1;
      check("sb dm_wen", dm_wen, 4'b0100);
      check("sb dm_wdata", dm_wdata, 32'hABAB_ABAB);
      step(5);
      check("sb single strobe", wen_pulses - base, 1);
      drop();
      issue(1, 0, 1, 0, 32'h0, 32'h0000_0200, 1, 5'd10, 32'h0000_0414);
      step(2);
      check("sb landed", MEM_WB_bus[63:32], 32'h00AB_0000);
      drop();

      // MEM_valid dropped in LOAD_WAIT
      base = over_pulses;
      issue(1, 0, 1, 0, 32'h0, 32'h0000_0100, 1, 5'd11, 32'h0000_0418);
      step(1);
      drop();
      step(2);
      check("abort no MEM_over", over_pulses - base, 0);
      check("abort MEM_WB_bus", MEM_WB_bus, 70'h0);
      check("abort dm_wen", dm_wen, 4'b0000);

      // reset in LOAD_WAIT
      base = over_pulses;
      issue(1, 0, 1, 0, 32'h0, 32'h0000_0100, 1, 5'd12, 32'h0000_041C);
      step(1);
      reset = 1'b1;
      MEM_valid = 1'b0;
      step(1);
      reset = 1'b0;
      step(2);
      check("rst-lw no MEM_over", over_pulses - base, 0);
      check("rst-lw MEM_WB_bus", MEM_WB_bus, 70'h0);
      check("rst-lw mem_misalign", mem_misalign, 1'b0);
      check("rst-lw dm_wen", dm_wen, 4'b0000);

      // misaligned word store
      issue(0, 1, 1, 0, 32'h1122_3344, 32'h0000_0101, 1, 5'd13, 32'h0000_0420);
      #1;
`ifdef MEM_ALIGN_CHECK_EN
      check("sw-mis dm_wen", dm_wen, 4'b0000);
      step(1);
      check("sw-mis flag", mem_misalign, 1'b1);
      check("sw-mis wb wen", MEM_WB_bus[69], 1'b0);
`else
      check("sw-mis dm_addr", dm_addr, 32'h0000_0100);
      check("sw-mis dm_wen", dm_wen, 4'b1111);
      step(1);
      check("sw-mis flag", mem_misalign, 1'b0);
`endif
      drop();
      step(2);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/st4_mem.md
ST4_MEM -- requirements
Module: st4_mem

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port MEM_valid  input  1  MEM stage holds a valid instruction (level, held until after MEM_over).
REQ-004 SHALL have port EXE_MEM_bus_r  input  106  {ld, st, ls_word, lb_sign, store_data[31:0], exe_result[31:0], wen, wdest[4:0], pc[31:0]}, MSB first.
REQ-005 SHALL have port dm_addr  output  32  data memory byte address.
REQ-006 SHALL have port dm_wen  output  4  data memory byte write enables.
REQ-007 SHALL have port dm_wdata  output  32  data memory write data.
REQ-008 SHALL have port dm_rdata  input  32  data memory read data, valid one cycle after address (synchronous RAM).
REQ-009 SHALL have port MEM_over  output  1  MEM access complete, MEM_WB_bus valid.
REQ-010 SHALL have port MEM_WB_bus  output  70  {wen, wdest[4:0], mem_result[31:0], pc[31:0]}, MSB first, toward writeback.
REQ-011 SHALL have port mem_misalign  output  1  misaligned word access flag.
REQ-012 SHALL have port MEM_pc  output  32  pc of instruction in MEM, for display.

Function
REQ-013 SHALL implement FSM states IDLE, LOAD_WAIT, DONE.
REQ-014 SHALL, in IDLE with MEM_valid=1 and ld=1, drive dm_addr=exe_result and go to LOAD_WAIT.
REQ-015 SHALL, in IDLE with MEM_valid=1 and ld=0, register the result (mem_result=exe_result) and go to DONE (latency 1 cycle).
REQ-016 SHALL, for a store, assert dm_wen only during the single IDLE cycle that accepts the instruction; never re-issue while in DONE.
REQ-017 SHALL drive word store dm_wen=4'b1111, dm_wdata=store_data; byte store dm_wen=4'b0001<<dm_addr[1:0], dm_wdata={4{store_data[7:0]}}.
REQ-018 SHALL, in LOAD_WAIT, capture dm_rdata: word load -> whole word; byte load -> byte lane dm_addr[1:0], sign-extended if lb_sign else zero-extended; then go to DONE (latency 2 cycles).
REQ-019 SHALL assert MEM_over while in DONE and hold MEM_WB_bus stable; leave DONE for IDLE only when MEM_valid=0.
REQ-020 SHALL, if MEM_valid drops in LOAD_WAIT, abort to IDLE without asserting MEM_over.
REQ-021 SHALL keep dm_wen=0 in LOAD_WAIT, DONE and whenever MEM_valid=0.
REQ-022 SHALL drive MEM_pc from the pc field of EXE_MEM_bus_r combinationally.

Reset
REQ-023 SHALL on reset: state=IDLE, MEM_over=0, MEM_WB_bus=0, mem_misalign=0, dm_wen=0; reset mid-LOAD_WAIT discards the load.

Configuration
REQ-024 SHALL, with MEM_ALIGN_CHECK_EN defined, flag word accesses with exe_result[1:0]!=0: mem_misalign=1 while in DONE, store suppressed (dm_wen=0), MEM_WB_bus wen=0.
REQ-025 SHALL, without MEM_ALIGN_CHECK_EN, tie mem_misalign=0 and force word-access dm_addr[1:0]=2'b00.

Structure
REQ-026 SHALL place bus widths (106, 70), EXE_MEM field positions and FSM state encoding in shared package st_bus_pkg.
REQ-027 SHALL implement load byte-select/extension in sub-module st4_mem_ldext (combinational, dm_rdata + addr[1:0] + ls_word + lb_sign -> 32-bit result).

Verification
REQ-028 SHALL cover ALU pass-through: exe_result=0x1234_5678, wen=1, wdest=5 -> MEM_over 1 cycle after accept, MEM_WB_bus={1,5,0x12345678,pc}.
REQ-029 SHALL cover word load: addr 0x100, RAM 0xDEAD_BEEF -> mem_result 0xDEADBEEF, MEM_over 2 cycles after accept.
REQ-030 SHALL cover byte load addr 0x103, RAM 0x80FF_0000: lb_sign=1 -> 0xFFFF_FF80; lb_sign=0 -> 0x0000_0080.
REQ-031 SHALL cover byte store addr 0x202, store_data 0xAB -> dm_wen=4'b0100, dm_wdata=0xABAB_ABAB for exactly one cycle while MEM_valid held 5 cycles.
REQ-032 SHALL cover MEM_valid dropped in LOAD_WAIT and reset in LOAD_WAIT -> IDLE, MEM_over never asserted, all outputs at reset values.
REQ-033 SHALL cover, with MEM_ALIGN_CHECK_EN, word store addr 0x101 -> dm_wen=0, mem_misalign=1, MEM_WB_bus wen=0; without macro -> dm_addr=0x100, dm_wen=4'b1111.
